// File: rtl/btn_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_conditioner_pkg
//   Shared board constants for the push-button front-end: clock rate, default
//   debounce / hold / repeat cycle counts, the per-channel FSM state encoding,
//   and small helpers used to size counters at elaboration time.
// -----------------------------------------------------------------------------
package btn_conditioner_pkg;

    localparam int unsigned CLK_HZ                  = 100_000_000;
    localparam int unsigned DEFAULT_NUM_BTN         = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms @ 100 MHz
    localparam int unsigned DEFAULT_HOLD_CYCLES     = 50_000_000;  // 500 ms
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 20_000_000;  // 200 ms

    // Channel FSM encoding is fixed so that the state can be probed on a board
    // debug header with a known meaning.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width of the hold/repeat counter: large enough to hold the bigger of the
    // two terminal counts.
    function automatic int unsigned rep_cnt_width(input int unsigned hold_cycles,
                                                  input int unsigned repeat_cycles);
        return $clog2(max_u(hold_cycles, repeat_cycles) + 1);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// btn_conditioner_if
//   Bundle between the raw board buttons and the conditioned button bus.
//   Signals (all NUM_BTN wide):
//     btn_raw      raw, asynchronous, active-high button inputs
//     btn_level    debounced, registered button level
//     btn_press    1-cycle pulse on debounced press or repeat tick
//     btn_release  1-cycle pulse on debounced release
//   Modports:
//     master  board side: drives btn_raw, consumes the conditioned outputs
//     slave   conditioner side: consumes btn_raw, drives the conditioned outputs
// -----------------------------------------------------------------------------
interface btn_conditioner_if #(
    parameter int unsigned NUM_BTN = 4
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface

// File: rtl/btn_conditioner_channel.sv
// -----------------------------------------------------------------------------
// btn_conditioner_channel
//   One button channel: 2-flop synchroniser, debounce counter and the
//   IDLE/HELD/REPEAT FSM that produces press/release pulses and the optional
//   hold-to-repeat ticks.
//   Ports:
//     clk            system clock
//     reset          synchronous, active-high reset
//     btn_raw_i      raw asynchronous button input
//     btn_level_o    debounced, registered level
//     btn_press_o    registered 1-cycle press / repeat pulse
//     btn_release_o  registered 1-cycle release pulse
// -----------------------------------------------------------------------------
module btn_conditioner_channel
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned REP_W = rep_cnt_width(HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] HOLD_LAST   = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REPEAT_LAST = REP_W'(REPEAT_CYCLES - 1);

    // sync_q[0] is the metastability-catching stage; only sync_q[1] is used.
    logic [1:0]       sync_q;
    logic [DB_W-1:0]  db_cnt_q,  db_cnt_d;
    logic             level_q,   level_d;
    btn_state_e       state_q,   state_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

    logic level_rise;
    logic level_fall;

    // Debounce: count consecutive cycles where the synchronised input
    // disagrees with the accepted level; accept the new level on the last one.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (sync_q[1] == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d = '0;
            level_d  = ~level_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // The FSM looks at the level edge being committed this cycle so that the
    // registered pulses line up with the registered level change.
    assign level_rise =  level_d & ~level_q;
    assign level_fall = ~level_d &  level_q;

    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (level_rise) begin
                    press_d   = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = ST_HELD;
                end
            end
            ST_HELD: begin
                // Release wins over a repeat tick due in the same cycle.
                if (level_fall) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (REPEAT_EN) begin
                    if (rep_cnt_q == HOLD_LAST) begin
                        press_d   = 1'b1;
                        rep_cnt_d = '0;
                        state_d   = ST_REPEAT;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (level_fall) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rep_cnt_q == REPEAT_LAST) begin
                    press_d   = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw_i};
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Push-button front-end: NUM_BTN independent channels, each synchronised,
//   debounced and turned into a level plus press/release pulses (with optional
//   hold-to-repeat on press). Feeds the display/clock-divider top level.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    btn_conditioner_if.slave: btn_raw in; btn_level, btn_press,
//            btn_release out
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BTN         = DEFAULT_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    btn_conditioner_if.slave bus
);

    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] release_w;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_conditioner_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .btn_raw_i     (bus.btn_raw[i]),
            .btn_level_o   (level_w[i]),
            .btn_press_o   (press_w[i]),
            .btn_release_o (release_w[i])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;

endmodule
